// File: rtl/reaction_if.sv
// reaction_if: light bar, button and result handshake between reaction_timer and its environment.
// The `best` signal exists only when REACTION_BEST_EN is defined.
interface reaction_if #(parameter int CNT_W = 10);
   logic [7:0]       lights;
   logic             button;
   logic             result_ack;
   logic [CNT_W-1:0] result;
   logic             result_valid;
   logic             jump_start;
   logic             busy;
`ifdef REACTION_BEST_EN
   logic [CNT_W-1:0] best;
   modport master (output lights, button, result_ack,
                   input  result, result_valid, jump_start, busy, best);
   modport slave  (input  lights, button, result_ack,
                   output result, result_valid, jump_start, busy, best);
`else
   modport master (output lights, button, result_ack,
                   input  result, result_valid, jump_start, busy);
   modport slave  (input  lights, button, result_ack,
                   output result, result_valid, jump_start, busy);
`endif
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer: F1 start-light reaction timer with jump-start detection and ack-held results.
// Define REACTION_BEST_EN to add the `best` (fastest non-timeout result) output.
module reaction_timer #(
   parameter int TICK_DIV = 1000,
   parameter int CNT_W    = 10,
   parameter int MAX_MS   = 999
) (
   input  logic      clk,
   input  logic      rst,
   reaction_if.slave rif
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARMED   = 3'd1;
   localparam logic [2:0] RUNNING = 3'd2;
   localparam logic [2:0] DONE    = 3'd3;
   localparam logic [2:0] FAULT   = 3'd4;
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MS);

   logic [2:0]       state_q, state_d;
   logic [7:0]       lights_q;
   logic             button_q;
   logic [PW-1:0]    pre_q, pre_d;
   logic [CNT_W-1:0] ms_q, ms_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             press, wrap, ms_max;
`ifdef REACTION_BEST_EN
   logic [CNT_W-1:0] best_q, best_d;
`endif

   assign press  = rif.button & ~button_q;
   assign wrap   = pre_q == PW'(TICK_DIV - 1);
   assign ms_max = ms_q == MAX_C;

   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      ms_d     = ms_q;
      result_d = result_q;
`ifdef REACTION_BEST_EN
      best_d   = best_q;
`endif
      case (state_q)
         IDLE:    if (rif.lights != 8'h00) state_d = ARMED;
         ARMED: begin
            if (press) state_d = FAULT;
            else if (rif.lights == 8'h00) begin
               state_d = (lights_q == 8'hFF) ? RUNNING : IDLE;
               pre_d   = '0;
               ms_d    = '0;
            end
         end
         RUNNING: begin
            pre_d = wrap ? '0 : pre_q + PW'(1);
            ms_d  = (wrap && !ms_max) ? ms_q + CNT_W'(1) : ms_q;
            // a press wins over a same-cycle timeout and reports the pre-increment count
            if (press) begin
               state_d  = DONE;
               result_d = ms_q;
`ifdef REACTION_BEST_EN
               best_d   = (ms_q < best_q) ? ms_q : best_q;
`endif
            end else if (wrap && ms_max) begin
               state_d  = DONE;
               result_d = MAX_C;
            end
         end
         DONE, FAULT: if (rif.result_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         lights_q <= '0;
         button_q <= 1'b0;
         pre_q    <= '0;
         ms_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         lights_q <= rif.lights;
         button_q <= rif.button;
         pre_q    <= pre_d;
         ms_q     <= ms_d;
         result_q <= result_d;
      end
   end

`ifdef REACTION_BEST_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) best_q <= MAX_C;
      else      best_q <= best_d;
   end
   assign rif.best = best_q;
`endif

   assign rif.result       = result_q;
   assign rif.result_valid = state_q == DONE;
   assign rif.jump_start   = state_q == FAULT;
   assign rif.busy         = (state_q == ARMED) || (state_q == RUNNING);
endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures driver reaction time for the F1 start-light game. Watches the 8-bit light bar from the start-sequence FSM and the player's button, starts timing when the lights go out after a full bar, and reports the elapsed whole milliseconds. A press before lights-out is flagged as a jump start. Each result is held until the downstream display/logger acknowledges it.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clock cycles per millisecond tick. Must be ≥2.
- `CNT_W`, default 10: width of the millisecond counter and result.
- `MAX_MS`, default 999: saturation and timeout value. Must be < 2^CNT_W.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; synchronous release is the integrator's job.
- `lights`  in  8  light bar from the start FSM; 8'hFF means all lights on, 8'h00 means all off.
- `button`  in  1  player button, level-high, already synchronised and debounced.
- `result_ack`  in  1  consumer acknowledge for `result_valid` or `jump_start`.
- `result`  out  CNT_W  reaction time in ms; valid while `result_valid`=1.
- `result_valid`  out  1  reaction result available.
- `jump_start`  out  1  press detected before or at lights-out.
- `busy`  out  1  high in ARMED or RUNNING.

## Operation
- Registers: `state`, `lights_q` (previous `lights`), `button_q`, prescaler (0..TICK_DIV-1), `ms_cnt`, and `result`.
- Press = `button & ~button_q`, a rising edge. Button level alone is never a press.
- IDLE:
  - `lights != 0` → ARMED.
  - Presses are ignored.
- ARMED:
  - A press → FAULT. This takes priority over every other condition, including lights-out in the same cycle.
  - `lights==0 && lights_q==8'hFF` → RUNNING; clear prescaler and `ms_cnt`.
  - `lights==0 && lights_q!=8'hFF` (aborted sequence) → IDLE.
- RUNNING:
  - Prescaler increments each cycle and wraps at TICK_DIV-1.
  - On wrap, `ms_cnt` increments, saturating at MAX_MS.
  - A press → DONE, with `result <= ms_cnt` (the value before any same-cycle increment).
  - If `ms_cnt==MAX_MS` and the prescaler wraps → DONE, with `result <= MAX_MS` (timeout).
  - Changes on `lights` are ignored.
- DONE:
  - `result_valid`=1, and `result` is held stable.
  - `result_ack`=1 → IDLE.
  - Presses and lights are ignored.
- FAULT:
  - `jump_start`=1, and `result` is unchanged.
  - `result_ack`=1 → IDLE.
- `result_ack` outside DONE/FAULT has no effect.
- `busy` = (state==ARMED || state==RUNNING).
- All outputs are registered or decoded from the registered state only. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: state IDLE, `result`=0, `result_valid`=0, `jump_start`=0, `busy`=0, `lights_q`=0, `button_q`=0, prescaler=0, `ms_cnt`=0.
- Reset mid-operation aborts immediately to those values. No result is emitted.
- Lights-out seen at cycle t: `busy` stays 1, and the prescaler is 0 at t+1.
- Press at cycle t in RUNNING: `result_valid`=1 and `result` valid at t+1.
- Press at cycle t in ARMED: `jump_start`=1 at t+1.
- `result_ack` high at cycle t in DONE/FAULT: the flag is 0 at t+1 and state is IDLE. A new sequence may arm at t+1 if `lights!=0`.
- Reaction resolution is 1 ms, truncating. A press in the first TICK_DIV cycles after lights-out reports 0.
- Timeout occurs (MAX_MS+1)·TICK_DIV cycles after lights-out.

## Configuration
- `REACTION_BEST_EN` defined:
  - Adds output `best`  out  CNT_W, the minimum of all non-timeout results since reset.
  - Reset value is MAX_MS.
  - Updated in the cycle `result_valid` rises, when the new result is smaller.
  - Jump starts and timeouts never update it.
- Not defined: the `best` port and its register are absent. All other behaviour is identical.

## Test plan
- TICK_DIV=4. Lights 01→03→…→FF, then 00. Press 10 cycles after lights-out → `result`=2, `result_valid`=1 one cycle after the press; ack → IDLE.
- Press while `lights`=8'h1F → `jump_start`=1 next cycle, `result_valid` stays 0. Press in the same cycle as lights 00 → `jump_start`.
- Lights 07→00 without reaching FF → back to IDLE, `busy`=0, no flags.
- TICK_DIV=4, MAX_MS=5, no press after lights-out → DONE after 24 cycles, `result`=5. Button held high throughout ARMED (no edge) → no jump start.
- Drop `rst` low mid-RUNNING, then release → all outputs 0, state IDLE. Held DONE ignores presses until ack.
- With `REACTION_BEST_EN`: results 7, 3, then 9 → `best` 7, 3, 3. A jump start leaves `best`=3.
